// File: rtl/edge_detect_pkg.sv
// edge_detect_pkg: shared definitions for the edge_detect_array block.
//   - mode_e     : edge-select encoding for the Mode input
//   - cnt_width  : glitch-filter counter width for a given FILT_CYCLES
//   - edge_sel   : Mode gating of a channel's rise/fall events
package edge_detect_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF  = 2'b00,
    MODE_FALL = 2'b01,
    MODE_RISE = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  // Counter must hold 0..FILT_CYCLES without wrapping.
  function automatic int unsigned cnt_width(input int unsigned filt_cycles);
    return $clog2(filt_cycles + 1);
  endfunction

  // Select which accepted transitions are reported on Edge_Sig.
  function automatic logic edge_sel(input mode_e mode, input logic rise, input logic fall);
    logic hit;
    hit = 1'b0;
    case (mode)
      MODE_FALL: hit = fall;
      MODE_RISE: hit = rise;
      MODE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// edge_detect_chan: one channel of edge_detect_array.
//   sync chain -> optional glitch filter -> level register -> rise/fall pulses.
// Build option: EDGE_DETECT_GLITCH_FILTER_EN adds the stability counter;
// without it the level follows the synchroniser output every cycle.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   sig        : asynchronous input line
//   level      : synchronised/filtered level (registered)
//   rise, fall : one-cycle pulses on an accepted transition (registered)
//   rise_c     : next-state of rise, for same-edge registering by the parent
//   fall_c     : next-state of fall, for same-edge registering by the parent
module edge_detect_chan
  import edge_detect_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
`ifdef EDGE_DETECT_GLITCH_FILTER_EN
  parameter int unsigned FILT_CYCLES = 4,
`endif
  parameter logic        IDLE_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   level_d;

  // Metastability synchroniser, index 0 samples the raw pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DETECT_GLITCH_FILTER_EN
  localparam int unsigned         CNT_W    = cnt_width(FILT_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive disagreeing cycles; the FILT_CYCLES-th accepts the new level.
  always_comb begin
    cnt_d   = '0;
    level_d = level;
    if (sync != level) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // No filter: level tracks the synchroniser output directly.
  always_comb begin
    level_d = sync;
  end
`endif

  assign rise_c = level_d & ~level;
  assign fall_c = ~level_d & level;

  // Level and pulses update together on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= IDLE_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      level <= level_d;
      rise  <= rise_c;
      fall  <= fall_c;
    end
  end

endmodule

// File: rtl/edge_detect_array.sv
// edge_detect_array: CH independent synchronise/filter/edge-detect channels.
// Build option: EDGE_DETECT_GLITCH_FILTER_EN enables the per-channel glitch
// filter (FILT_CYCLES stable cycles before a level is accepted).
// Ports:
//   CLK, RSTn  : clock (rising edge), async active-low reset
//   Sig_In     : CH asynchronous input lines
//   Mode       : Edge_Sig select, 00 off / 01 fall / 10 rise / 11 both
//   Level_Out  : CH synchronised, filtered levels
//   Rise_Sig   : CH one-cycle pulses on accepted 0->1
//   Fall_Sig   : CH one-cycle pulses on accepted 1->0
//   Edge_Sig   : CH Rise/Fall pulses gated by Mode sampled on the accepting edge
module edge_detect_array
  import edge_detect_pkg::*;
#(
  parameter int unsigned CH          = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4,
  parameter logic        IDLE_LEVEL  = 1'b1
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [CH-1:0] Sig_In,
  input  logic [1:0]    Mode,
  output logic [CH-1:0] Level_Out,
  output logic [CH-1:0] Rise_Sig,
  output logic [CH-1:0] Fall_Sig,
  output logic [CH-1:0] Edge_Sig
);

  logic [CH-1:0] rise_c;
  logic [CH-1:0] fall_c;
  logic [CH-1:0] edge_d;

  for (genvar i = 0; i < CH; i++) begin : g_chan
    edge_detect_chan #(
      .SYNC_STAGES (SYNC_STAGES),
`ifdef EDGE_DETECT_GLITCH_FILTER_EN
      .FILT_CYCLES (FILT_CYCLES),
`endif
      .IDLE_LEVEL  (IDLE_LEVEL)
    ) u_chan (
      .clk    (CLK),
      .rst_n  (RSTn),
      .sig    (Sig_In[i]),
      .level  (Level_Out[i]),
      .rise   (Rise_Sig[i]),
      .fall   (Fall_Sig[i]),
      .rise_c (rise_c[i]),
      .fall_c (fall_c[i])
    );
  end

`ifndef EDGE_DETECT_GLITCH_FILTER_EN
  // FILT_CYCLES only shapes the filter, which is not built here.
  if (FILT_CYCLES == 0) begin : g_filt_unused
  end
`endif

  // Mode is applied to the next-state events so it is sampled on the accepting edge.
  always_comb begin
    edge_d = '0;
    for (int i = 0; i < int'(CH); i++) begin
      edge_d[i] = edge_sel(mode_e'(Mode), rise_c[i], fall_c[i]);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Edge_Sig <= '0;
    end else begin
      Edge_Sig <= edge_d;
    end
  end

endmodule

// File: tb/tb_edge_detect_array.sv
// tb_edge_detect_array: randomized and directed checks of edge_detect_array
// against a window-based reference model of the input history.
module tb_edge_detect_array;

  localparam int unsigned CH   = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned FILT = 4;
`ifdef EDGE_DETECT_GLITCH_FILTER_EN
  localparam int unsigned FE = FILT;
`else
  localparam int unsigned FE = 1;
`endif
  localparam int unsigned LAT = SYNC + FE;
  localparam int unsigned HW  = SYNC + FE;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic [CH-1:0] Sig_In;
  logic [1:0]    Mode;
  logic [CH-1:0] Level_Out, Rise_Sig, Fall_Sig, Edge_Sig;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: sampled input history per channel, newest at index 0.
  logic [HW-1:0] hist [CH];
  logic [CH-1:0] m_level, m_rise, m_fall, m_edge;

  edge_detect_array #(
    .CH(CH), .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .IDLE_LEVEL(1'b1)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .Sig_In(Sig_In), .Mode(Mode),
    .Level_Out(Level_Out), .Rise_Sig(Rise_Sig), .Fall_Sig(Fall_Sig), .Edge_Sig(Edge_Sig)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < int'(CH); c++) hist[c] = '1;
    m_level = '1;
    m_rise  = '0;
    m_fall  = '0;
    m_edge  = '0;
  endtask

  // A new level is accepted once the FE most recent synchronised samples
  // (input delayed by SYNC edges) all disagree with the current level.
  task automatic model_step();
    logic all_diff;
    logic nl;
    if (!RSTn) begin
      model_reset();
      return;
    end
    for (int c = 0; c < int'(CH); c++) begin
      hist[c] = {hist[c][HW-2:0], Sig_In[c]};
      all_diff = 1'b1;
      for (int j = int'(SYNC); j < int'(SYNC + FE); j++)
        if (hist[c][j] == m_level[c]) all_diff = 1'b0;
      nl = all_diff ? ~m_level[c] : m_level[c];
      m_rise[c] = nl & ~m_level[c];
      m_fall[c] = ~nl & m_level[c];
      case (Mode)
        2'd1:    m_edge[c] = m_fall[c];
        2'd2:    m_edge[c] = m_rise[c];
        2'd3:    m_edge[c] = m_rise[c] | m_fall[c];
        default: m_edge[c] = 1'b0;
      endcase
      m_level[c] = nl;
    end
  endtask

  task automatic check_all();
    check("level", 32'(Level_Out), 32'(m_level));
    check("rise",  32'(Rise_Sig),  32'(m_rise));
    check("fall",  32'(Fall_Sig),  32'(m_fall));
    check("edge",  32'(Edge_Sig),  32'(m_edge));
  endtask

  // Inputs are changed at negedge; one tick = active edge, model update, check.
  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_level"}, 32'(Level_Out), 32'hF);
    check({tag, "_rise"},  32'(Rise_Sig),  32'h0);
    check({tag, "_fall"},  32'(Fall_Sig),  32'h0);
    check({tag, "_edge"},  32'(Edge_Sig),  32'h0);
  endtask

  initial begin
    int fall_cnt, rise_cnt;
    RSTn   = 1'b0;
    Sig_In = '1;
    Mode   = 2'b11;
    model_reset();

    // Reset with idle inputs, then idle for 20 cycles.
    @(negedge CLK);
    @(negedge CLK);
    check_reset_vals("rst");
    RSTn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_reset_vals("idle");
    end

    // Single fall on ch0, Mode=fall: pulses at edge LAT.
    Mode = 2'b01;
    Sig_In[0] = 1'b0;
    for (int k = 1; k <= int'(LAT) + 2; k++) begin
      tick();
      check("dir_fall", 32'(Fall_Sig[0]), 32'(k == int'(LAT)));
      check("dir_edge", 32'(Edge_Sig[0]), 32'(k == int'(LAT)));
      check("dir_lvl",  32'(Level_Out[0]), 32'(k < int'(LAT)));
    end
    // Back high with Mode=fall: Rise pulses but Edge does not.
    Sig_In[0] = 1'b1;
    for (int k = 1; k <= int'(LAT) + 2; k++) begin
      tick();
      check("dir_rise",   32'(Rise_Sig[0]), 32'(k == int'(LAT)));
      check("dir_noedge", 32'(Edge_Sig[0]), 32'h0);
    end
    // Fall again with Mode=rise: no Edge pulse.
    Mode = 2'b10;
    Sig_In[0] = 1'b0;
    ticks(int'(LAT) + 2);
    Sig_In[0] = 1'b1;
    ticks(int'(LAT) + 2);

    // Three-cycle low glitch on ch1.
    Mode = 2'b11;
    fall_cnt = 0;
    rise_cnt = 0;
    Sig_In[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      fall_cnt += int'(Fall_Sig[1]);
      rise_cnt += int'(Rise_Sig[1]);
    end
    Sig_In[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      fall_cnt += int'(Fall_Sig[1]);
      rise_cnt += int'(Rise_Sig[1]);
    end
    check("glitch_falls", 32'(fall_cnt), 32'(FE > 3 ? 0 : 1));
    check("glitch_rises", 32'(rise_cnt), 32'(FE > 3 ? 0 : 1));

    // Mode 01 -> 00 right before the accepting edge: Fall pulses, Edge stays low.
    Mode = 2'b01;
    Sig_In[2] = 1'b0;
    ticks(int'(LAT) - 1);
    Mode = 2'b00;
    tick();
    check("modeoff_fall", 32'(Fall_Sig[2]), 32'h1);
    check("modeoff_edge", 32'(Edge_Sig[2]), 32'h0);
    // Mode 00 -> 01 right before the accepting edge: Edge pulses.
    Sig_In[2] = 1'b1;
    ticks(int'(LAT) + 1);
    Sig_In[2] = 1'b0;
    ticks(int'(LAT) - 1);
    Mode = 2'b01;
    tick();
    check("modeon_edge", 32'(Edge_Sig[2]), 32'h1);
    Mode = 2'b00;
    tick();
    check("modeon_hold", 32'(Edge_Sig[2]), 32'h0);
    Sig_In[2] = 1'b1;
    ticks(int'(LAT) + 2);

    // Reset during a pending fall on ch3, input held low through reset.
    Mode = 2'b11;
    Sig_In[3] = 1'b0;
    ticks(4 < int'(LAT) ? 4 : int'(LAT) - 1);
    RSTn = 1'b0;
    model_reset();
    #1;
    check_reset_vals("midrst");
    ticks(3);
    check_reset_vals("midrst_hold");
    RSTn = 1'b1;
    for (int k = 1; k <= int'(LAT) + 2; k++) begin
      tick();
      check("rel_fall", 32'(Fall_Sig[3]), 32'(k == int'(LAT)));
    end
    Sig_In[3] = 1'b1;
    ticks(int'(LAT) + 2);

    // Random traffic: mixed glitch lengths, staggered channels, random Mode.
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < int'(CH); c++)
        if ($urandom_range(5, 0) == 0) Sig_In[c] = ~Sig_In[c];
      if ($urandom_range(7, 0) == 0) Mode = 2'($urandom_range(3, 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
